// File: rtl/banked_operational_memory.sv
// Banked operational memory: NUM_MODES privilege banks behind a fetch port and a data port,
// with 1-cycle registered reads. Define OPMEM_ACCESS_FAULT_EN to enable out-of-range checking.
module banked_operational_memory #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 16,
  parameter int NUM_MODES    = 2,
  parameter int MODE_W       = 1,
  parameter int BANK0_ADDR_W = 16,
  parameter int BANKN_ADDR_W = 15,
  parameter     INIT_FILE    = "RAM.mif"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MODE_W-1:0]   operationMode,
  input  logic [ADDR_W-1:0]   fetchAddress,
  input  logic                fetchEnable,
  output logic [DATA_W-1:0]   fetchOutput,
  output logic                fetchValid,
  input  logic [ADDR_W-1:0]   memAccessAddress,
  input  logic                memAccessWren,
  input  logic [DATA_W/8-1:0] memAccessByteEn,
  input  logic [DATA_W-1:0]   memAccessData,
  input  logic                memAccessRden,
  output logic [DATA_W-1:0]   memAccessOutput,
  output logic                memAccessValid,
  output logic                memAccessFault
);

  localparam int LANES = DATA_W / 8;

  logic [MODE_W-1:0] mode_sel;
  logic [MODE_W-1:0] fetch_sel_q;
  logic [MODE_W-1:0] data_sel_q;
  logic [DATA_W-1:0] fetch_rd [NUM_MODES];
  logic [DATA_W-1:0] data_rd  [NUM_MODES];
`ifdef OPMEM_ACCESS_FAULT_EN
  logic [NUM_MODES-1:0] data_oob_vec;
`endif

  // Modes beyond the last bank fold onto the last bank.
  assign mode_sel = (operationMode >= MODE_W'(NUM_MODES - 1)) ? MODE_W'(NUM_MODES - 1)
                                                              : operationMode;

  for (genvar b = 0; b < NUM_MODES; b++) begin : g_bank
    localparam int AW = (b == 0) ? BANK0_ADDR_W : BANKN_ADDR_W;

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] fetch_word;
    logic [DATA_W-1:0] data_word;
    logic [AW-1:0]     fetch_idx;
    logic [AW-1:0]     data_idx;
    logic              hit;
    logic              fetch_oob;
    logic              data_oob;

    assign fetch_idx = fetchAddress[AW-1:0];
    assign data_idx  = memAccessAddress[AW-1:0];
    assign hit       = (mode_sel == MODE_W'(b));

`ifdef OPMEM_ACCESS_FAULT_EN
    assign fetch_oob       = |(fetchAddress >> AW);
    assign data_oob        = |(memAccessAddress >> AW);
    assign data_oob_vec[b] = data_oob;
`else
    assign fetch_oob = 1'b0;
    assign data_oob  = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (hit && memAccessWren && !data_oob) begin
        for (int i = 0; i < LANES; i++) begin
          if (memAccessByteEn[i]) mem[data_idx][8*i +: 8] <= memAccessData[8*i +: 8];
        end
      end
    end

    // Non-blocking reads against the same edge's write give read-before-write on both ports.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fetch_word <= '0;
        data_word  <= '0;
      end else begin
        if (hit && fetchEnable)   fetch_word <= fetch_oob ? '0 : mem[fetch_idx];
        if (hit && memAccessRden) data_word  <= data_oob  ? '0 : mem[data_idx];
      end
    end

    assign fetch_rd[b] = fetch_word;
    assign data_rd[b]  = data_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_sel_q    <= '0;
      data_sel_q     <= '0;
      fetchValid     <= 1'b0;
      memAccessValid <= 1'b0;
    end else begin
      fetchValid     <= fetchEnable;
      memAccessValid <= memAccessRden;
      if (fetchEnable)   fetch_sel_q <= mode_sel;
      if (memAccessRden) data_sel_q  <= mode_sel;
    end
  end

  // Bank registers only update on their own requests, so the muxed outputs hold between reads.
  assign fetchOutput     = fetch_rd[fetch_sel_q];
  assign memAccessOutput = data_rd[data_sel_q];

`ifdef OPMEM_ACCESS_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) memAccessFault <= 1'b0;
    else        memAccessFault <= data_oob_vec[mode_sel] && (memAccessWren || memAccessRden);
  end
`else
  assign memAccessFault = 1'b0;
`endif

endmodule
